booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer sharing one 16-bit radix-2 Booth multiplier between two requesters.
//   Holds multiplier in clear while idle; on grant runs clear -> load -> N compute cycles -> capture.
//   Returns the signed 2N-bit product to the granted requester over a valid/ready response channel.
//   Sits between the ALU issue logic and the multiplier datapath. One operation in flight at a time.
// PARAMETERS
//   WIDTH       16     operand width; product is 2*WIDTH; must match multiplier
//   RUN_CYCLES  WIDTH  compute cycles the multiplier needs after load (one Booth step per clk)
// PORTS
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-low reset
//   req0_valid   in   1        requester 0 operand valid
//   req0_ready   out  1        requester 0 accepted this cycle
//   req0_m       in   WIDTH    requester 0 multiplicand, two's complement
//   req0_q       in   WIDTH    requester 0 multiplier, two's complement
//   rsp0_valid   out  1        product valid for requester 0
//   rsp0_ready   in   1        requester 0 takes product
//   rsp0_p       out  2*WIDTH  product for requester 0
//   req1_*/rsp1_*  same as requester 0, for requester 1
//   mul_reset    out  1        sync active-high clear to multiplier
//   mul_load     out  1        operand load strobe to multiplier
//   mul_m        out  WIDTH    operand M to multiplier
//   mul_q        out  WIDTH    operand Q to multiplier
//   mul_p        in   2*WIDTH  multiplier product register
//   busy         out  1        high whenever state != IDLE
// BEHAVIOUR
//   States: IDLE, CLR, LOAD, RUN, CAP, RESP. Outputs Moore-decoded from registered state.
//   Reset (reset=0, async): state=IDLE, last_grant=1, owner=0, run_cnt=0, op regs=0, rsp*_p=0,
//     rsp*_valid=0, req*_ready=0, mul_load=0, mul_reset=1, busy=0.
//   IDLE: mul_reset=1. req*_ready combinational: only in IDLE; if one valid, grant it; if both,
//     grant the one != last_grant. Accept edge latches m/q into op regs, owner, last_grant -> CLR.
//   CLR: mul_reset=1 for exactly 1 cycle -> LOAD.
//   LOAD: mul_load=1 for exactly 1 cycle, mul_m/mul_q = op regs -> RUN, run_cnt=0.
//   RUN: mul_reset=0, mul_load=0; run_cnt increments each edge; after RUN_CYCLES edges -> CAP.
//   CAP: latch mul_p into rsp<owner>_p -> RESP.
//   RESP: rsp<owner>_valid=1; hold until rsp<owner>_ready=1 on an edge -> IDLE.
//   Latency: rsp_valid first high RUN_CYCLES+3 (=19) edges after accept edge.
//   rsp*_p holds last captured value until the next capture for that requester.
//   mul_m/mul_q driven from op regs always; stable through LOAD and RUN.
//   Requests arriving while busy wait (ready=0); requesters keep valid/operands stable.
//   New request may be accepted in the IDLE cycle immediately after RESP handshake.
//   Reset mid-operation: abort, outputs to reset values, in-flight result discarded.
//   Product: signed 2*WIDTH; M=-2^(WIDTH-1) is outside the supported operand range.
// CONFIGURATION
//   BOOTH_ZERO_BYPASS_EN defined: on accept, if m==0 or q==0, latch 0 into rsp<owner>_p
//     and go IDLE -> RESP directly; rsp_valid after 1 edge, mul_load never pulses.
//   Not defined: zero operands take the full CLR/LOAD/RUN/CAP path (19-edge latency).
// TESTING
//   Async reset asserted mid-RUN -> same cycle: busy=0, mul_reset=1, mul_load=0, rsp*_valid=0.
//   req0 m=0x0003 q=0xFFFB -> rsp0_p=0xFFFF_FFF1 19 edges after accept; mul_load high 1 cycle.
//   req0,req1 valid same cycle after reset -> req0 granted; req1 granted the IDLE cycle after rsp0 handshake.
//   rsp0_ready low 10 cycles -> rsp0_valid, rsp0_p stable; req0/req1_ready stay 0; busy=1.
//   req1 m=0x0000 q=0x1234 -> p=0; bypass: 1-edge latency, no mul_load; else 19 edges.
//   req0 valid continuously, req1 pending -> grants alternate 0,1,0; m=0x7FFF q=0x7FFF -> 0x3FFF_0001.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_arbiter
// Description : Round-robin arbiter/sequencer sharing one radix-2 Booth
//               multiplier between two requesters. Optional macro
//               BOOTH_ZERO_BYPASS_EN returns zero products without running
//               the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter #(
    parameter int WIDTH      = 16,
    parameter int RUN_CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_m,
    input  logic [WIDTH-1:0]     req0_q,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_p,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_m,
    input  logic [WIDTH-1:0]     req1_q,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_p,

    output logic                 mul_reset,
    output logic                 mul_load,
    output logic [WIDTH-1:0]     mul_m,
    output logic [WIDTH-1:0]     mul_q,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy
);

    localparam int CNT_W = $clog2(RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_run_last = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_CAP  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t               state_q,      state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q,      owner_d;
    logic [CNT_W-1:0]     run_cnt_q,    run_cnt_d;
    logic [WIDTH-1:0]     op_m_q,       op_m_d;
    logic [WIDTH-1:0]     op_q_q,       op_q_d;
    logic [2*WIDTH-1:0]   rsp0_p_q,     rsp0_p_d;
    logic [2*WIDTH-1:0]   rsp1_p_q,     rsp1_p_d;
    logic                 rsp0_valid_q, rsp0_valid_d;
    logic                 rsp1_valid_q, rsp1_valid_d;
    logic                 mul_reset_q,  mul_reset_d;
    logic                 mul_load_q,   mul_load_d;
    logic                 busy_q,       busy_d;

    logic                 w_idle;
    logic                 w_grant0;
    logic                 w_grant1;
    logic [WIDTH-1:0]     w_sel_m;
    logic [WIDTH-1:0]     w_sel_q;
    logic                 w_rsp_ready;
`ifdef BOOTH_ZERO_BYPASS_EN
    logic                 w_zero;
`endif

    // On contention the requester that was not served last wins; reset
    // gating keeps ready low while the block is held in reset.
    assign w_idle   = reset && (state_q == S_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid ||  last_grant_q);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !last_grant_q);

    assign w_sel_m     = w_grant1 ? req1_m : req0_m;
    assign w_sel_q     = w_grant1 ? req1_q : req0_q;
    assign w_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
`ifdef BOOTH_ZERO_BYPASS_EN
    assign w_zero      = (w_sel_m == '0) || (w_sel_q == '0);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        run_cnt_d    = run_cnt_q;
        op_m_d       = op_m_q;
        op_q_d       = op_q_q;
        rsp0_p_d     = rsp0_p_q;
        rsp1_p_d     = rsp1_p_q;

        case (state_q)
            S_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    owner_d      = w_grant1;
                    last_grant_d = w_grant1;
                    op_m_d       = w_sel_m;
                    op_q_d       = w_sel_q;
                    state_d      = S_CLR;
`ifdef BOOTH_ZERO_BYPASS_EN
                    if (w_zero) begin
                        state_d = S_RESP;
                        if (w_grant1) begin
                            rsp1_p_d = '0;
                        end else begin
                            rsp0_p_d = '0;
                        end
                    end
`endif
                end
            end
            S_CLR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == c_run_last) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                if (owner_q) begin
                    rsp1_p_d = mul_p;
                end else begin
                    rsp0_p_d = mul_p;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        mul_reset_d  = (state_d == S_IDLE) || (state_d == S_CLR);
        mul_load_d   = (state_d == S_LOAD);
        busy_d       = (state_d != S_IDLE);
        rsp0_valid_d = (state_d == S_RESP) && !owner_d;
        rsp1_valid_d = (state_d == S_RESP) &&  owner_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            run_cnt_q    <= '0;
            op_m_q       <= '0;
            op_q_q       <= '0;
            rsp0_p_q     <= '0;
            rsp1_p_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            mul_reset_q  <= 1'b1;
            mul_load_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            run_cnt_q    <= run_cnt_d;
            op_m_q       <= op_m_d;
            op_q_q       <= op_q_d;
            rsp0_p_q     <= rsp0_p_d;
            rsp1_p_q     <= rsp1_p_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            mul_reset_q  <= mul_reset_d;
            mul_load_q   <= mul_load_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_p     = rsp0_p_q;
    assign rsp1_p     = rsp1_p_q;
    assign mul_reset  = mul_reset_q;
    assign mul_load   = mul_load_q;
    assign mul_m      = op_m_q;
    assign mul_q      = op_q_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_arbiter
// Description : Scoreboard bench for booth_mul_arbiter with an iterative
//               Booth multiplier model on the datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_arbiter;

    localparam int WIDTH = 16;

    logic                 clk;
    logic                 reset;
    logic                 req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic                 req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0]     req0_m, req0_q, req1_m, req1_q;
    logic [2*WIDTH-1:0]   rsp0_p, rsp1_p;
    logic                 mul_reset, mul_load, busy;
    logic [WIDTH-1:0]     mul_m, mul_q;
    logic [2*WIDTH-1:0]   mul_p;

    booth_mul_arbiter #(.WIDTH(WIDTH), .RUN_CYCLES(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_m     (req0_m),
        .req0_q     (req0_q),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_p     (rsp0_p),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_m     (req1_m),
        .req1_q     (req1_q),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_p     (rsp1_p),
        .mul_reset  (mul_reset),
        .mul_load   (mul_load),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_p      (mul_p),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Iterative radix-2 Booth multiplier: one step per clock after load.
    logic [WIDTH-1:0] bm_a, bm_q, bm_m;
    logic             bm_q1;
    int               bm_steps;

    function automatic logic [2*WIDTH:0] booth_step(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] m,
                                                    input logic q1);
        logic [WIDTH-1:0] s;
        s = a;
        if (q[0] && !q1) s = a - m;
        else if (!q[0] && q1) s = a + m;
        return {s[WIDTH-1], s, q};
    endfunction

    always @(posedge clk) begin
        if (mul_reset) begin
            bm_a <= '0; bm_q <= '0; bm_m <= '0; bm_q1 <= 1'b0; bm_steps <= WIDTH;
        end else if (mul_load) begin
            bm_a <= '0; bm_q <= mul_q; bm_m <= mul_m; bm_q1 <= 1'b0; bm_steps <= 0;
        end else if (bm_steps < WIDTH) begin
            {bm_a, bm_q, bm_q1} <= booth_step(bm_a, bm_q, bm_m, bm_q1);
            bm_steps <= bm_steps + 1;
        end
    end
    assign mul_p = {bm_a, bm_q};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [2*WIDTH-1:0] exp0[$];
    logic [2*WIDTH-1:0] exp1[$];
    int                 grant_log[$];
    int cyc = 0, op_acc = 0, op_lat = 0, op_nload = 0, op_loads = 0;
    int last_acc1 = 0, hs0_cyc = 0;
    bit seen0 = 0, seen1 = 0;

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        logic signed [2*WIDTH-1:0] p;
        p = $signed(m) * $signed(q);
        return p;
    endfunction

    task automatic note_accept(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        op_acc   = cyc;
        op_loads = 0;
        op_lat   = WIDTH + 3;
        op_nload = 1;
`ifdef BOOTH_ZERO_BYPASS_EN
        if (m == '0 || q == '0) begin
            op_lat   = 1;
            op_nload = 0;
        end
`endif
    endtask

    // Monitor: sampled on the falling edge, between active edges.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                exp0.delete();
                exp1.delete();
                seen0 = 0;
                seen1 = 0;
            end else begin
                if (req0_valid && req0_ready) begin
                    exp0.push_back(ref_mul(req0_m, req0_q));
                    grant_log.push_back(0);
                    note_accept(req0_m, req0_q);
                end
                if (req1_valid && req1_ready) begin
                    exp1.push_back(ref_mul(req1_m, req1_q));
                    grant_log.push_back(1);
                    last_acc1 = cyc;
                    note_accept(req1_m, req1_q);
                end
                if (mul_load) op_loads++;
                if (rsp0_valid && !seen0) begin
                    seen0 = 1;
                    check("lat0", cyc - op_acc - 1, op_lat);
                    check("loads0", op_loads, op_nload);
                end
                if (rsp1_valid && !seen1) begin
                    seen1 = 1;
                    check("lat1", cyc - op_acc - 1, op_lat);
                    check("loads1", op_loads, op_nload);
                end
                if (rsp0_valid && rsp0_ready) begin
                    check("rsp0_pending", exp0.size() > 0, 1);
                    if (exp0.size() > 0) check("rsp0_p", rsp0_p, exp0.pop_front());
                    seen0   = 0;
                    hs0_cyc = cyc;
                end
                if (rsp1_valid && rsp1_ready) begin
                    check("rsp1_pending", exp1.size() > 0, 1);
                    if (exp1.size() > 0) check("rsp1_p", rsp1_p, exp1.pop_front());
                    seen1 = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit id, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        int    n;
        bit    got;
        string tag;
        n   = 0;
        got = 0;
        tag = id ? "req1_accept" : "req0_accept";
        if (id) begin req1_m = m; req1_q = q; req1_valid = 1'b1; end
        else    begin req0_m = m; req0_q = q; req0_valid = 1'b1; end
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = id ? req1_ready : req0_ready;
        end
        check(tag, got, 1);
        tick();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle", busy || exp0.size() != 0 || exp1.size() != 0, 0);
        tick();
    endtask

    task automatic reset_pulse();
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset      = 1'b0;
        req0_valid = 1'b1; req0_m = 16'h0003; req0_q = 16'h0004;
        req1_valid = 1'b1; req1_m = 16'h0005; req1_q = 16'h0006;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_mul_reset", mul_reset, 1);
        check("rst_mul_load", mul_load, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_rsp_p", {rsp0_p, rsp1_p}, 0);
        check("rst_mul_ops", {mul_m, mul_q}, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b1;
        tick();

        // Basic signed product through the full sequence.
        do_req(0, 16'h0003, 16'hFFFB);
        wait_idle();
        check("p_3x-5", rsp0_p, 32'hFFFF_FFF1);

        // Simultaneous requests straight after reset.
        reset_pulse();
        grant_log.delete();
        fork
            do_req(0, 16'h0011, 16'h0022);
            do_req(1, 16'hFFFF, 16'h0009);
        join
        wait_idle();
        check("tie_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("tie_first", grant_log[0], 0);
            check("tie_second", grant_log[1], 1);
        end
        check("req1_after_hs0", last_acc1, hs0_cyc + 1);

        // Response back-pressure with a competing request waiting.
        rsp0_ready = 1'b0;
        do_req(0, 16'h7FFF, 16'h7FFF);
        n = 0;
        while (!rsp0_valid && n < 100) begin tick(); n++; end
        check("stall_wait", rsp0_valid, 1);
        fork
            do_req(1, 16'h0000, 16'h1234);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall_valid", rsp0_valid, 1);
                    check("stall_p", rsp0_p, 32'h3FFF_0001);
                    check("stall_ready", {req0_ready, req1_ready}, 0);
                    check("stall_busy", busy, 1);
                end
                tick();
                rsp0_ready = 1'b1;
            end
        join
        wait_idle();
        check("zero_p", rsp1_p, 0);

        // Continuous req0 against one pending req1.
        grant_log.delete();
        fork
            begin
                do_req(0, 16'h7FFF, 16'h7FFF);
                do_req(0, 16'h0101, 16'hFF80);
            end
            do_req(1, 16'h8001, 16'h0002);
        join
        wait_idle();
        check("rr_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("rr_g0", grant_log[0], 0);
            check("rr_g1", grant_log[1], 1);
            check("rr_g2", grant_log[2], 0);
        end

        // Asynchronous reset in the middle of the compute phase.
        do_req(0, 16'h1234, 16'hFEDC);
        repeat (5) tick();
        check("run_busy", busy, 1);
        check("run_mul_reset", mul_reset, 0);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_mul_reset", mul_reset, 1);
        check("abort_mul_load", mul_load, 0);
        check("abort_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("abort_rsp0_p", rsp0_p, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        do_req(1, 16'hFFF9, 16'h0005);
        wait_idle();
        check("recover_p", rsp1_p, 32'hFFFF_FFDD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
